id_ex_stage: RTL and testbench
==============================

Name: id_ex_stage

Overview:
ID/EX pipeline register for the 32-bit MIPS core. It sits directly upstream of ALU and feeds its ALU_s, a and b inputs.
- Captures decoded operands and control each cycle; supports stall (hold) and flush (bubble insert).
- Applies EX/MEM and MEM/WB result forwarding and immediate selection, so ALU operands are hazard-resolved.

Parameters:
DATA_W, 32, datapath width
REG_ADDR_W, 5, register index width
ALU_S_W, 3, ALU operation select width
IMM_W, 16, instruction immediate width

Ports:
clk  in  1  rising-edge clock
rst_n  in  1  asynchronous active-low reset
stall  in  1  hold all stage registers
flush  in  1  replace captured instruction with bubble
id_valid  in  1  ID holds a real instruction
id_ALU_s  in  ALU_S_W  ALU operation from decode
id_rs_data  in  DATA_W  register-file read port 1
id_rt_data  in  DATA_W  register-file read port 2
id_imm  in  IMM_W  raw immediate
id_use_imm  in  1  b takes extended immediate instead of rt
id_sign_ext  in  1  1 = sign-extend immediate, 0 = zero-extend
id_rs_addr, id_rt_addr, id_rd_addr  in  REG_ADDR_W  source and destination indices
id_reg_write  in  1  instruction writes rd
exmem_reg_write  in  1  EX/MEM write enable
exmem_rd_addr  in  REG_ADDR_W  EX/MEM destination
exmem_result  in  DATA_W  EX/MEM ALU result (ALU c)
memwb_reg_write  in  1  MEM/WB write enable
memwb_rd_addr  in  REG_ADDR_W  MEM/WB destination
memwb_result  in  DATA_W  MEM/WB writeback value
ex_valid  out  1  EX holds a real instruction
ALU_s  out  ALU_S_W  to ALU ALU_s
a  out  DATA_W  to ALU a (forwarded rs)
b  out  DATA_W  to ALU b (immediate or forwarded rt)
ex_store_data  out  DATA_W  forwarded rt, always, for stores
ex_rd_addr  out  REG_ADDR_W  destination to EX/MEM
ex_reg_write  out  1  gated write enable to EX/MEM
fwd_a_sel, fwd_b_sel  out  2  forwarding source select (00 reg, 01 EX/MEM, 10 MEM/WB)

Behaviour:
- Reset (async, rst_n=0): every stage register is cleared to 0.
  - ex_valid=0, ex_reg_write=0, ALU_s=0, ex_rd_addr=0.
  - Stored rs/rt data, immediate, addresses and use_imm are cleared to 0.
  - Therefore a=0, b=0, ex_store_data=0 and fwd sel=00, provided forwarding inputs do not match address 0. Address 0 is never forwarded.
- Clock edge priority: flush > stall > capture.
  - flush=1: load the reset image (bubble); stall is ignored that cycle.
  - stall=1, flush=0: all registers hold their values. Forwarding stays live, so a and b may change with the EX/MEM and MEM/WB inputs.
  - Otherwise: capture all id_* fields. Immediate extension is done at capture and stored DATA_W wide.
  - ex_reg_write is captured as id_reg_write & id_valid.
- Latency: 1 cycle from ID inputs to registered outputs. a, b, ex_store_data and fwd_*_sel are combinational from stage registers and forwarding inputs.
- Forwarding per source (rs→a, rt→store/b):
  - Select 01 if exmem_reg_write, exmem_rd_addr==src, src!=0.
  - Else select 10 if memwb_reg_write, memwb_rd_addr==src, src!=0.
  - Else select 00 (captured register data).
  - EX/MEM wins when both match.
- b = stored use_imm ? extended immediate : forwarded rt. fwd_b_sel reports the rt forwarding decision even when use_imm=1.
- When ex_valid=0, forwarding is still computed but has no architectural effect, because ex_reg_write=0.
- Reset asserted mid-stall or mid-flush clears immediately. The first capture occurs on the first clock edge after release with stall=0.

Decomposition:
- mips_pkg holds the following constants; the block is parameterised from them.
  - DATA_W, REG_ADDR_W, ALU_S_W, IMM_W.
  - ALU op encodings for ALU_s.
  - Forwarding select encodings FWD_REG=2'b00, FWD_EXMEM=2'b01, FWD_MEMWB=2'b10.
- One sub-module, fwd_mux: source address, register data, both bypass ports → select and value. It is instantiated twice (rs, rt).

Test Plan:
- Reset: rst_n=0 mid-run with exmem_reg_write=1, exmem_rd_addr=0 → ex_valid=0, ALU_s=0, a=0, b=0, fwd_a_sel=00.
- Plain capture: id_ALU_s=5, rs_data=1, rt_data=3, use_imm=0, no bypass matches → next cycle ALU_s=5, a=1, b=3, ex_reg_write=1.
- Immediate: imm=16'hFFFE, use_imm=1, sign_ext=1 → b=32'hFFFFFFFE. Repeat with sign_ext=0 → b=32'h0000FFFE.
- Forward priority: rs_addr=rt_addr=7 captured; exmem(7, 100), memwb(7, 200) → a=100, fwd_a_sel=01. Drop exmem_reg_write → a=200, fwd_a_sel=10. Address 0 with both matching → a=captured data, sel 00.
- Stall/flush: stall=1 for 3 cycles while id_* changes → outputs unchanged. stall=1 and flush=1 together → bubble (ex_valid=0, ex_reg_write=0, ALU_s=0).
- Invalid capture: id_valid=0, id_reg_write=1 → ex_reg_write=0, ex_valid=0.

Source files
------------

// File: rtl/mips_pkg.sv
// Shared widths and encodings for the 32-bit MIPS core pipeline stages.
package mips_pkg;

    localparam int unsigned DATA_W     = 32;
    localparam int unsigned REG_ADDR_W = 5;
    localparam int unsigned ALU_S_W    = 3;
    localparam int unsigned IMM_W      = 16;

    typedef enum logic [ALU_S_W-1:0] {
        ALU_AND = 3'b000,
        ALU_OR  = 3'b001,
        ALU_ADD = 3'b010,
        ALU_XOR = 3'b011,
        ALU_NOR = 3'b100,
        ALU_SLL = 3'b101,
        ALU_SUB = 3'b110,
        ALU_SLT = 3'b111
    } alu_op_e;

    typedef enum logic [1:0] {
        FWD_REG   = 2'b00,
        FWD_EXMEM = 2'b01,
        FWD_MEMWB = 2'b10
    } fwd_sel_e;

endpackage

// File: rtl/fwd_mux.sv
// Operand bypass selector: picks the freshest value for one source register.
module fwd_mux
    import mips_pkg::*;
#(
    parameter int unsigned DATA_W     = mips_pkg::DATA_W,
    parameter int unsigned REG_ADDR_W = mips_pkg::REG_ADDR_W
) (
    input  logic [REG_ADDR_W-1:0] src_addr,
    input  logic [DATA_W-1:0]     reg_data,
    input  logic                  exmem_reg_write,
    input  logic [REG_ADDR_W-1:0] exmem_rd_addr,
    input  logic [DATA_W-1:0]     exmem_result,
    input  logic                  memwb_reg_write,
    input  logic [REG_ADDR_W-1:0] memwb_rd_addr,
    input  logic [DATA_W-1:0]     memwb_result,
    output logic [1:0]            sel,
    output logic [DATA_W-1:0]     data
);

    logic src_nonzero;

    assign src_nonzero = (src_addr != '0);

    // $zero is hardwired, so a pending write to it must never be bypassed
    always_comb begin
        sel  = FWD_REG;
        data = reg_data;
        if (src_nonzero && exmem_reg_write && (exmem_rd_addr == src_addr)) begin
            sel  = FWD_EXMEM;
            data = exmem_result;
        end else if (src_nonzero && memwb_reg_write && (memwb_rd_addr == src_addr)) begin
            sel  = FWD_MEMWB;
            data = memwb_result;
        end
    end

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with stall/flush control, immediate extension and
// EX/MEM, MEM/WB operand forwarding feeding the ALU.
module id_ex_stage
    import mips_pkg::*;
#(
    parameter int unsigned DATA_W     = mips_pkg::DATA_W,
    parameter int unsigned REG_ADDR_W = mips_pkg::REG_ADDR_W,
    parameter int unsigned ALU_S_W    = mips_pkg::ALU_S_W,
    parameter int unsigned IMM_W      = mips_pkg::IMM_W
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  stall,
    input  logic                  flush,
    input  logic                  id_valid,
    input  logic [ALU_S_W-1:0]    id_ALU_s,
    input  logic [DATA_W-1:0]     id_rs_data,
    input  logic [DATA_W-1:0]     id_rt_data,
    input  logic [IMM_W-1:0]      id_imm,
    input  logic                  id_use_imm,
    input  logic                  id_sign_ext,
    input  logic [REG_ADDR_W-1:0] id_rs_addr,
    input  logic [REG_ADDR_W-1:0] id_rt_addr,
    input  logic [REG_ADDR_W-1:0] id_rd_addr,
    input  logic                  id_reg_write,
    input  logic                  exmem_reg_write,
    input  logic [REG_ADDR_W-1:0] exmem_rd_addr,
    input  logic [DATA_W-1:0]     exmem_result,
    input  logic                  memwb_reg_write,
    input  logic [REG_ADDR_W-1:0] memwb_rd_addr,
    input  logic [DATA_W-1:0]     memwb_result,
    output logic                  ex_valid,
    output logic [ALU_S_W-1:0]    ALU_s,
    output logic [DATA_W-1:0]     a,
    output logic [DATA_W-1:0]     b,
    output logic [DATA_W-1:0]     ex_store_data,
    output logic [REG_ADDR_W-1:0] ex_rd_addr,
    output logic                  ex_reg_write,
    output logic [1:0]            fwd_a_sel,
    output logic [1:0]            fwd_b_sel
);

    logic                  valid_q,     valid_d;
    logic [ALU_S_W-1:0]    alu_s_q,     alu_s_d;
    logic [DATA_W-1:0]     rs_data_q,   rs_data_d;
    logic [DATA_W-1:0]     rt_data_q,   rt_data_d;
    logic [DATA_W-1:0]     imm_q,       imm_d;
    logic                  use_imm_q,   use_imm_d;
    logic [REG_ADDR_W-1:0] rs_addr_q,   rs_addr_d;
    logic [REG_ADDR_W-1:0] rt_addr_q,   rt_addr_d;
    logic [REG_ADDR_W-1:0] rd_addr_q,   rd_addr_d;
    logic                  reg_write_q, reg_write_d;

    logic [DATA_W-1:0]     imm_ext;
    logic [DATA_W-1:0]     rt_fwd;

    // Extension happens before the register so EX sees a full-width constant
    assign imm_ext = {{(DATA_W-IMM_W){id_sign_ext & id_imm[IMM_W-1]}}, id_imm};

    always_comb begin
        valid_d     = valid_q;
        alu_s_d     = alu_s_q;
        rs_data_d   = rs_data_q;
        rt_data_d   = rt_data_q;
        imm_d       = imm_q;
        use_imm_d   = use_imm_q;
        rs_addr_d   = rs_addr_q;
        rt_addr_d   = rt_addr_q;
        rd_addr_d   = rd_addr_q;
        reg_write_d = reg_write_q;
        if (flush) begin
            valid_d     = 1'b0;
            alu_s_d     = '0;
            rs_data_d   = '0;
            rt_data_d   = '0;
            imm_d       = '0;
            use_imm_d   = 1'b0;
            rs_addr_d   = '0;
            rt_addr_d   = '0;
            rd_addr_d   = '0;
            reg_write_d = 1'b0;
        end else if (!stall) begin
            valid_d     = id_valid;
            alu_s_d     = id_ALU_s;
            rs_data_d   = id_rs_data;
            rt_data_d   = id_rt_data;
            imm_d       = imm_ext;
            use_imm_d   = id_use_imm;
            rs_addr_d   = id_rs_addr;
            rt_addr_d   = id_rt_addr;
            rd_addr_d   = id_rd_addr;
            reg_write_d = id_reg_write & id_valid;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q     <= 1'b0;
            alu_s_q     <= '0;
            rs_data_q   <= '0;
            rt_data_q   <= '0;
            imm_q       <= '0;
            use_imm_q   <= 1'b0;
            rs_addr_q   <= '0;
            rt_addr_q   <= '0;
            rd_addr_q   <= '0;
            reg_write_q <= 1'b0;
        end else begin
            valid_q     <= valid_d;
            alu_s_q     <= alu_s_d;
            rs_data_q   <= rs_data_d;
            rt_data_q   <= rt_data_d;
            imm_q       <= imm_d;
            use_imm_q   <= use_imm_d;
            rs_addr_q   <= rs_addr_d;
            rt_addr_q   <= rt_addr_d;
            rd_addr_q   <= rd_addr_d;
            reg_write_q <= reg_write_d;
        end
    end

    fwd_mux #(
        .DATA_W     (DATA_W),
        .REG_ADDR_W (REG_ADDR_W)
    ) u_fwd_rs (
        .src_addr        (rs_addr_q),
        .reg_data        (rs_data_q),
        .exmem_reg_write (exmem_reg_write),
        .exmem_rd_addr   (exmem_rd_addr),
        .exmem_result    (exmem_result),
        .memwb_reg_write (memwb_reg_write),
        .memwb_rd_addr   (memwb_rd_addr),
        .memwb_result    (memwb_result),
        .sel             (fwd_a_sel),
        .data            (a)
    );

    fwd_mux #(
        .DATA_W     (DATA_W),
        .REG_ADDR_W (REG_ADDR_W)
    ) u_fwd_rt (
        .src_addr        (rt_addr_q),
        .reg_data        (rt_data_q),
        .exmem_reg_write (exmem_reg_write),
        .exmem_rd_addr   (exmem_rd_addr),
        .exmem_result    (exmem_result),
        .memwb_reg_write (memwb_reg_write),
        .memwb_rd_addr   (memwb_rd_addr),
        .memwb_result    (memwb_result),
        .sel             (fwd_b_sel),
        .data            (rt_fwd)
    );

    assign ex_valid      = valid_q;
    assign ALU_s         = alu_s_q;
    assign ex_rd_addr    = rd_addr_q;
    assign ex_reg_write  = reg_write_q;
    assign ex_store_data = rt_fwd;
    assign b             = use_imm_q ? imm_q : rt_fwd;

endmodule

// File: tb/tb_id_ex_stage.sv
// Scoreboard bench for id_ex_stage: directed stimulus pushes hand-computed
// expectations, a separate monitor pops and compares them against the DUT.
module tb_id_ex_stage;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        stall, flush;
    logic        id_valid;
    logic [2:0]  id_ALU_s;
    logic [31:0] id_rs_data, id_rt_data;
    logic [15:0] id_imm;
    logic        id_use_imm, id_sign_ext;
    logic [4:0]  id_rs_addr, id_rt_addr, id_rd_addr;
    logic        id_reg_write;
    logic        exmem_reg_write;
    logic [4:0]  exmem_rd_addr;
    logic [31:0] exmem_result;
    logic        memwb_reg_write;
    logic [4:0]  memwb_rd_addr;
    logic [31:0] memwb_result;
    logic        ex_valid;
    logic [2:0]  ALU_s;
    logic [31:0] a, b, ex_store_data;
    logic [4:0]  ex_rd_addr;
    logic        ex_reg_write;
    logic [1:0]  fwd_a_sel, fwd_b_sel;

    id_ex_stage dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .stall           (stall),
        .flush           (flush),
        .id_valid        (id_valid),
        .id_ALU_s        (id_ALU_s),
        .id_rs_data      (id_rs_data),
        .id_rt_data      (id_rt_data),
        .id_imm          (id_imm),
        .id_use_imm      (id_use_imm),
        .id_sign_ext     (id_sign_ext),
        .id_rs_addr      (id_rs_addr),
        .id_rt_addr      (id_rt_addr),
        .id_rd_addr      (id_rd_addr),
        .id_reg_write    (id_reg_write),
        .exmem_reg_write (exmem_reg_write),
        .exmem_rd_addr   (exmem_rd_addr),
        .exmem_result    (exmem_result),
        .memwb_reg_write (memwb_reg_write),
        .memwb_rd_addr   (memwb_rd_addr),
        .memwb_result    (memwb_result),
        .ex_valid        (ex_valid),
        .ALU_s           (ALU_s),
        .a               (a),
        .b               (b),
        .ex_store_data   (ex_store_data),
        .ex_rd_addr      (ex_rd_addr),
        .ex_reg_write    (ex_reg_write),
        .fwd_a_sel       (fwd_a_sel),
        .fwd_b_sel       (fwd_b_sel)
    );

    always #5 clk = ~clk;

    typedef struct {
        string       name;
        logic        ev;
        logic [2:0]  alu;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] st;
        logic [4:0]  rd;
        logic        rw;
        logic [1:0]  fa;
        logic [1:0]  fb;
    } exp_t;

    exp_t exp_q[$];
    event push_ev;
    int   n_checks = 0;
    int   n_fail   = 0;

    task automatic chk(input string n, input string f, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s.%s: got %h, expected %h", n, f, act, req);
        end
    endtask

    // Monitor: drains the scoreboard against whatever the DUT is presenting
    initial begin
        exp_t e;
        forever begin
            @(push_ev);
            while (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                chk(e.name, "ex_valid",      {31'd0, ex_valid},     {31'd0, e.ev});
                chk(e.name, "ALU_s",         {29'd0, ALU_s},        {29'd0, e.alu});
                chk(e.name, "a",             a,                     e.a);
                chk(e.name, "b",             b,                     e.b);
                chk(e.name, "ex_store_data", ex_store_data,         e.st);
                chk(e.name, "ex_rd_addr",    {27'd0, ex_rd_addr},   {27'd0, e.rd});
                chk(e.name, "ex_reg_write",  {31'd0, ex_reg_write}, {31'd0, e.rw});
                chk(e.name, "fwd_a_sel",     {30'd0, fwd_a_sel},    {30'd0, e.fa});
                chk(e.name, "fwd_b_sel",     {30'd0, fwd_b_sel},    {30'd0, e.fb});
            end
        end
    end

    task automatic expect_out(input string n, input logic ev, input logic [2:0] alu,
                              input logic [31:0] ea, input logic [31:0] eb, input logic [31:0] st,
                              input logic [4:0] rd, input logic rw, input logic [1:0] fa,
                              input logic [1:0] fb);
        exp_t e;
        #1;
        e.name = n; e.ev = ev; e.alu = alu; e.a = ea; e.b = eb; e.st = st;
        e.rd = rd; e.rw = rw; e.fa = fa; e.fb = fb;
        exp_q.push_back(e);
        -> push_ev;
        #1;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_id(input logic v, input logic [2:0] alu, input logic [31:0] rs,
                          input logic [31:0] rt, input logic [15:0] imm, input logic ui,
                          input logic se, input logic [4:0] rsa, input logic [4:0] rta,
                          input logic [4:0] rda, input logic rw);
        id_valid = v; id_ALU_s = alu; id_rs_data = rs; id_rt_data = rt; id_imm = imm;
        id_use_imm = ui; id_sign_ext = se; id_rs_addr = rsa; id_rt_addr = rta;
        id_rd_addr = rda; id_reg_write = rw;
    endtask

    task automatic set_byp(input logic ew, input logic [4:0] ea, input logic [31:0] er,
                           input logic mw, input logic [4:0] ma, input logic [31:0] mr);
        exmem_reg_write = ew; exmem_rd_addr = ea; exmem_result = er;
        memwb_reg_write = mw; memwb_rd_addr = ma; memwb_result = mr;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0; stall = 1'b0; flush = 1'b0;
        set_id(1'b1, 3'd5, 32'h1111, 32'h2222, 16'h8000, 1'b1, 1'b1, 5'd3, 5'd4, 5'd5, 1'b1);
        set_byp(1'b1, 5'd0, 32'hDEAD, 1'b1, 5'd0, 32'hBEEF);
        repeat (3) tick();
        expect_out("reset", 0, 0, 0, 0, 0, 0, 0, 2'b00, 2'b00);
        rst_n = 1'b1;

        set_byp(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
        set_id(1'b1, 3'd5, 32'd1, 32'd3, 16'h0000, 1'b0, 1'b0, 5'd1, 5'd2, 5'd3, 1'b1);
        tick();
        expect_out("capture", 1, 5, 32'd1, 32'd3, 32'd3, 5'd3, 1, 2'b00, 2'b00);

        set_id(1'b1, 3'd2, 32'h11, 32'h22, 16'hFFFE, 1'b1, 1'b1, 5'd4, 5'd5, 5'd6, 1'b1);
        tick();
        expect_out("imm_sext", 1, 2, 32'h11, 32'hFFFF_FFFE, 32'h22, 5'd6, 1, 2'b00, 2'b00);
        id_sign_ext = 1'b0;
        tick();
        expect_out("imm_zext", 1, 2, 32'h11, 32'h0000_FFFE, 32'h22, 5'd6, 1, 2'b00, 2'b00);

        set_id(1'b1, 3'd3, 32'hAAA, 32'hBBB, 16'h0000, 1'b0, 1'b0, 5'd7, 5'd7, 5'd8, 1'b1);
        tick();
        expect_out("fwd_none", 1, 3, 32'hAAA, 32'hBBB, 32'hBBB, 5'd8, 1, 2'b00, 2'b00);
        set_byp(1'b1, 5'd7, 32'd100, 1'b1, 5'd7, 32'd200);
        expect_out("fwd_exmem", 1, 3, 32'd100, 32'd100, 32'd100, 5'd8, 1, 2'b01, 2'b01);
        exmem_reg_write = 1'b0;
        expect_out("fwd_memwb", 1, 3, 32'd200, 32'd200, 32'd200, 5'd8, 1, 2'b10, 2'b10);

        set_id(1'b1, 3'd1, 32'h55, 32'h66, 16'h0000, 1'b0, 1'b0, 5'd0, 5'd0, 5'd9, 1'b1);
        set_byp(1'b1, 5'd0, 32'd100, 1'b1, 5'd0, 32'd200);
        tick();
        expect_out("fwd_addr0", 1, 1, 32'h55, 32'h66, 32'h66, 5'd9, 1, 2'b00, 2'b00);

        set_id(1'b1, 3'd2, 32'h10, 32'h20, 16'h1234, 1'b1, 1'b1, 5'd0, 5'd9, 5'd10, 1'b1);
        set_byp(1'b1, 5'd9, 32'h900, 1'b0, 5'd0, 32'd0);
        tick();
        expect_out("fwd_b_imm", 1, 2, 32'h10, 32'h1234, 32'h900, 5'd10, 1, 2'b00, 2'b01);

        set_id(1'b1, 3'd4, 32'h123, 32'h456, 16'h0000, 1'b0, 1'b0, 5'd10, 5'd11, 5'd12, 1'b1);
        exmem_reg_write = 1'b0;
        tick();
        expect_out("pre_stall", 1, 4, 32'h123, 32'h456, 32'h456, 5'd12, 1, 2'b00, 2'b00);

        stall = 1'b1;
        set_id(1'b1, 3'd7, 32'hF0, 32'hF1, 16'hFFFF, 1'b1, 1'b1, 5'd13, 5'd14, 5'd15, 1'b0);
        for (int i = 0; i < 3; i++) begin
            tick();
            expect_out("stall_hold", 1, 4, 32'h123, 32'h456, 32'h456, 5'd12, 1, 2'b00, 2'b00);
        end
        set_byp(1'b1, 5'd10, 32'h999, 1'b0, 5'd0, 32'd0);
        expect_out("stall_fwd", 1, 4, 32'h999, 32'h456, 32'h456, 5'd12, 1, 2'b01, 2'b00);

        flush = 1'b1;
        tick();
        expect_out("flush", 0, 0, 0, 0, 0, 0, 0, 2'b00, 2'b00);

        flush = 1'b0; stall = 1'b0; exmem_reg_write = 1'b0;
        set_id(1'b0, 3'd6, 32'h31, 32'h32, 16'h0000, 1'b0, 1'b0, 5'd1, 5'd2, 5'd3, 1'b1);
        tick();
        expect_out("invalid", 0, 6, 32'h31, 32'h32, 32'h32, 5'd3, 0, 2'b00, 2'b00);

        set_id(1'b1, 3'd5, 32'h41, 32'h42, 16'h0000, 1'b0, 1'b0, 5'd1, 5'd2, 5'd17, 1'b1);
        tick();
        expect_out("pre_reset", 1, 5, 32'h41, 32'h42, 32'h42, 5'd17, 1, 2'b00, 2'b00);
        stall = 1'b1;
        set_byp(1'b1, 5'd0, 32'hDEAD, 1'b1, 5'd0, 32'hBEEF);
        rst_n = 1'b0;
        expect_out("reset_mid_stall", 0, 0, 0, 0, 0, 0, 0, 2'b00, 2'b00);
        rst_n = 1'b1;
        tick();
        expect_out("post_reset_stall", 0, 0, 0, 0, 0, 0, 0, 2'b00, 2'b00);
        stall = 1'b0;
        set_byp(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
        tick();
        expect_out("first_capture", 1, 5, 32'h41, 32'h42, 32'h42, 5'd17, 1, 2'b00, 2'b00);

        for (int i = 0; i < 20 && exp_q.size() > 0; i++) #1;
        if (exp_q.size() > 0) begin
            n_fail++;
            $display("FAIL drain: %0d expectations left unchecked, expected 0", exp_q.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
